pir_event_log: RTL and testbench
================================

# pir_event_log

Event logger and arbiter for the three PIR motion sensors. It detects each sensor's threshold crossing and shares one 8-entry event buffer among the three sensors using round-robin arbitration. Each accepted event is stored as an 8-bit record (sensor id plus timestamp), which the host drains through a read port. It sits beside the PIR alarm controller on the same sensor buses and gives that controller's alarm decisions an event history.

## Interface
- THRESHOLD, 50: motion threshold; a sensor level is "active" when pir_sensor_n >= THRESHOLD (7-bit unsigned compare).
- DEPTH, 8: buffer entries; fixed at 8 (3-bit pointers, 4-bit count).
- HOLDOFF_CYCLES, 100: per-sensor re-trigger suppression after a grant; range 0..255; 0 disables holdoff.
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  arms event detection.
- clear  in  1  synchronous flush of buffer, pending flags and overflow.
- pir_sensor_1 / pir_sensor_2 / pir_sensor_3  in  7 each  sensor levels.
- rd_en  in  1  pop request.
- rd_data  out  8  popped record: [7:6] sensor id (01, 10, 11); [5:0] timestamp.
- rd_valid  out  1  one-cycle strobe; rd_data is valid while it is high.
- count  out  4  entries held, 0..8.
- empty / full  out  1 each  count==0 / count==8.
- overflow  out  1  sticky flag: an event was dropped because the buffer was full.

## Operation
- **Reset values:** rd_data=0, rd_valid=0, count=0, empty=1, full=0, overflow=0. Internally, all pending flags, holdoffs, prev_level and timestamp are 0, and the round-robin last-grant pointer is sensor 3.
- **Timestamp:** 6-bit free-running counter, +1 every cycle, wraps 63->0. A record holds the timestamp value at its write edge.
- **Edge detect per sensor n:** event_n = enable & active_n & ~prev_n & (holdoff_n==0). prev_n <= active_n every cycle, regardless of enable.
  - An event sets pending_n.
  - A level held active generates only one event.
  - An event arriving while pending_n=1 merges into the existing pending flag.
- **Arbiter:** each cycle, pick one pending sensor, searching from (last grant + 1) cyclically.
  - If full=0: write the record, clear that sensor's pending flag, load holdoff_n=HOLDOFF_CYCLES, and update the last-grant pointer.
  - If full=1: clear the chosen pending flag, set overflow, leave holdoff and pointer unchanged. Exactly one request is dropped per cycle.
  - A write is blocked whenever full=1 at the edge, even if a read is accepted in the same cycle.
- **Holdoff:** a nonzero holdoff_n decrements by 1 each cycle and saturates at 0.
- **Read:** rd_en & ~empty pops the oldest entry. rd_data is registered and rd_valid=1 for the following cycle only. rd_en while empty is ignored (rd_valid=0, rd_data holds its last value).
- **Simultaneous read and write (not full):** count is unchanged and both pointers advance.
- **enable=0:**
  - Clears all pending flags and holdoffs; no new events are detected.
  - Buffer contents, count and the read path are unaffected.
- **clear=1:**
  - Sets count=0 and both pointers to 0; clears overflow and pending flags.
  - Any read or write in that cycle is suppressed.
  - The timestamp keeps running.
  - Takes priority over everything except rst.
- **rst mid-operation:** all outputs take their reset values immediately, with no clock edge required. Buffer contents are treated as discarded.

## Timing
- **Latency:** a level seen active at edge E0 (with prev low) sets pending at E0. If granted at E1, the entry is written at E1 and count/empty/full update after E1. Input to count change is 2 edges.
- **Throughput:** at most one write per cycle. Three simultaneous events are written on three consecutive edges in round-robin order.
- **Read:** rd_en sampled at edge R gives rd_data/rd_valid after R; count updates at R.
- **Outputs:** all outputs are registered; none are combinational from the inputs.

## Test plan
- **Single event:** rst, then enable=1; pir_sensor_2 goes 0->60 and is held. Expect exactly one entry (count=1, 2 edges after the input change). Pulse rd_en: rd_valid=1 for one cycle, rd_data[7:6]=2'b10, count=0, empty=1.
- **Arbitration order:** right after reset, all three sensors go 0->60 on the same edge. Expect records with ids 01, 10, 11 on consecutive edges, timestamps t, t+1, t+2 (mod 64). Then sensor 1 and sensor 3 fire together again: expect 01 first (last grant was 3).
- **Threshold and holdoff:**
  - pir_sensor_1 at 49: no entry; at 50: one entry.
  - With HOLDOFF_CYCLES=100, sensor 1 alternates between 60 and 0 every 10 cycles. Rises within 100 cycles of a grant are ignored; the first rise after holdoff reaches 0 is logged.
- **Overflow:** 9 separated events with no reads. Expect count=8, full=1, overflow=1, 9th event dropped. Read 8 times: the records come out in write order and empty=1. Pulse clear: overflow=0.
- **Reset/clear mid-operation:** with count=5 and rd_en active, assert rst between clock edges. Expect count=0, empty=1, rd_valid=0 immediately. Separately, clear with a simultaneous event and read: count=0, and no write or rd_valid that cycle.

Source files
------------

// File: rtl/pir_event_log.sv
// pir_event_log: detects rising threshold crossings on three PIR sensors and logs them
// round-robin into an 8-entry FIFO of {sensor id, timestamp} records.
module pir_event_log #(
    parameter int THRESHOLD      = 50,
    parameter int DEPTH          = 8,
    parameter int HOLDOFF_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [6:0] pir_sensor_1,
    input  logic [6:0] pir_sensor_2,
    input  logic [6:0] pir_sensor_3,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [3:0] count,
    output logic       empty,
    output logic       full,
    output logic       overflow
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] hold_q [3];
    logic [7:0] hold_d [3];
    logic [6:0] lvl [3];
    logic [5:0] ts_q;
    logic [2:0] prev_q, pend_q, pend_d, active, evt, req, gmask;
    logic [2:0] wptr_q, rptr_q;
    logic [1:0] last_q, o1, o2, gnt;
    logic [3:0] count_q;
    logic [7:0] rdd_q;
    logic       ovf_q, rdv_q, grant, wr, rd;

    assign rd_data  = rdd_q;
    assign rd_valid = rdv_q;
    assign count    = count_q;
    assign empty    = count_q == 4'd0;
    assign full     = count_q == 4'(DEPTH);
    assign overflow = ovf_q;

    always_comb begin
        lvl[0] = pir_sensor_1;
        lvl[1] = pir_sensor_2;
        lvl[2] = pir_sensor_3;
        for (int n = 0; n < 3; n++) begin
            active[n] = lvl[n] >= 7'(THRESHOLD);
            evt[n]    = enable & active[n] & ~prev_q[n] & (hold_q[n] == 8'd0);
        end
        req    = enable ? pend_q : 3'b000;
        // search order starts one past the last granted sensor
        o1     = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
        o2     = o1 == 2'd2 ? 2'd0 : o1 + 2'd1;
        gnt    = req[o1] ? o1 : req[o2] ? o2 : last_q;
        grant  = |req & ~clear;
        wr     = grant & ~full;
        rd     = rd_en & ~empty & ~clear;
        gmask  = grant ? 3'b001 << gnt : 3'b000;
        pend_d = (clear | ~enable) ? 3'b000 : (pend_q & ~gmask) | evt;
        for (int n = 0; n < 3; n++)
            hold_d[n] = !enable ? 8'd0 :
                        (wr && gnt == 2'(n)) ? 8'(HOLDOFF_CYCLES) :
                        hold_q[n] - 8'(hold_q[n] != 8'd0);
    end

    always_ff @(posedge clk)
        if (wr) mem_q[wptr_q] <= {gnt + 2'd1, ts_q};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ts_q    <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            for (int n = 0; n < 3; n++) hold_q[n] <= '0;
            last_q  <= 2'd2;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdd_q   <= '0;
            rdv_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q   <= ts_q + 6'd1;
            prev_q <= active;
            pend_q <= pend_d;
            for (int n = 0; n < 3; n++) hold_q[n] <= hold_d[n];
            if (clear) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                rdv_q   <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                rdv_q   <= rd;
                count_q <= count_q + 4'(wr) - 4'(rd);
                if (rd) rdd_q <= mem_q[rptr_q];
                if (rd) rptr_q <= rptr_q + 3'd1;
                if (wr) wptr_q <= wptr_q + 3'd1;
                if (wr) last_q <= gnt;
                if (grant && full) ovf_q <= 1'b1;
            end
        end
endmodule

// File: tb/tb_pir_event_log.sv
// tb_pir_event_log: randomized stimulus against a queue-based event log model.
module tb_pir_event_log;
    logic       clk = 0, rst = 1, enable = 0, clear = 0, rd_en = 0;
    logic [6:0] s1 = 0, s2 = 0, s3 = 0;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, overflow;
    logic [3:0] count;
    int         total = 0, bad = 0;

    pir_event_log dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .pir_sensor_1(s1), .pir_sensor_2(s2), .pir_sensor_3(s3),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         m_ts, m_last;
    bit         m_prev [3];
    bit         m_pend [3];
    int         m_hold [3];
    logic [7:0] m_q [$];
    bit         m_ovf, m_rdv;
    logic [7:0] m_rdd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_ts = 0; m_last = 2; m_ovf = 0; m_rdv = 0; m_rdd = 0;
        m_q.delete();
        for (int n = 0; n < 3; n++) begin m_prev[n] = 0; m_pend[n] = 0; m_hold[n] = 0; end
    endfunction

    function automatic void m_step();
        int  lv [3];
        bit  act [3];
        bit  ev [3];
        int  g = -1;
        bit  was_full = m_q.size() == 8;
        bit  written = 0;
        lv[0] = s1; lv[1] = s2; lv[2] = s3;
        for (int n = 0; n < 3; n++) begin
            act[n] = lv[n] >= 50;
            ev[n]  = enable && act[n] && !m_prev[n] && m_hold[n] == 0;
        end
        if (enable && !clear)
            for (int k = 1; k <= 3; k++)
                if (g < 0 && m_pend[(m_last + k) % 3]) g = (m_last + k) % 3;
        if (clear) begin
            m_q.delete(); m_ovf = 0; m_rdv = 0;
        end else begin
            m_rdv = rd_en && m_q.size() > 0;
            if (m_rdv) m_rdd = m_q.pop_front();
            if (g >= 0) begin
                if (was_full) m_ovf = 1;
                else begin
                    m_q.push_back({2'(g + 1), 6'(m_ts)});
                    m_last = g;
                    written = 1;
                end
            end
        end
        for (int n = 0; n < 3; n++) begin
            m_hold[n] = !enable ? 0 : (written && g == n) ? 100 : (m_hold[n] > 0 ? m_hold[n] - 1 : 0);
            m_pend[n] = (!enable || clear) ? 0 : ((m_pend[n] && g != n) || ev[n]);
            m_prev[n] = act[n];
        end
        m_ts = (m_ts + 1) % 64;
    endfunction

    task automatic check_all();
        chk("count", count, m_q.size());
        chk("empty", empty, m_q.size() == 0);
        chk("full", full, m_q.size() == 8);
        chk("overflow", overflow, m_ovf);
        chk("rd_valid", rd_valid, m_rdv);
        chk("rd_data", rd_data, m_rdd);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) m_step();
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [6:0] pick();
        case ($urandom_range(0, 7))
            0: return 7'd0;
            1: return 7'd20;
            2: return 7'd49;
            3: return 7'd50;
            4: return 7'd51;
            5: return 7'd60;
            6: return 7'd127;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic drive(input int rdp, input bit clr_on);
        if ($urandom_range(0, 7) == 0) s1 = pick();
        if ($urandom_range(0, 7) == 0) s2 = pick();
        if ($urandom_range(0, 7) == 0) s3 = pick();
        enable = $urandom_range(0, 99) != 0;
        clear  = clr_on && $urandom_range(0, 299) == 0;
        rd_en  = $urandom_range(0, 99) < rdp;
    endtask

    task automatic async_reset();
        rst = 1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_overflow", overflow, 0);
        m_reset();
        cycle();
        rst = 0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 0;
        enable = 1;
        repeat (1000) begin drive(0, 0); cycle(); end
        async_reset();
        repeat (1500) begin drive(50, 1); cycle(); end
        rd_en = 1;
        async_reset();
        repeat (1500) begin drive(10, 1); cycle(); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
